// File: rtl/ins_loader_pkg.sv
// Shared types and sizing for the boot-time instruction loader.
// Latency: n/a (package). Backpressure: n/a.
package ins_loader_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV_LO,
        ST_RECV_HI,
        ST_CHECK,
        ST_FIN
    } state_t;
endpackage

// File: rtl/ins_loader_if.sv
// Control, byte-stream and memory-write signals of the instruction loader.
// Latency: n/a (wiring only). Backpressure: in_ready qualifies in_valid.
interface ins_loader_if import ins_loader_pkg::*; ();
    logic                       start;
    logic [ADDR_W:0]            word_count;
    logic [BYTE_W-1:0]          in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic                       cpu_hold;

    modport master (
        input  start, word_count, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold
    );
    modport slave (
        output start, word_count, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, err, cpu_hold
    );
endinterface

// File: rtl/ins_loader_csum.sv
// 8-bit wrapping running sum; zero flags that sum plus the incoming byte wraps to 0.
// Latency: sum updates 1 cycle after add_en; zero is combinational. Backpressure: none.
module ins_loader_csum import ins_loader_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [BYTE_W-1:0] sum,
    output logic              zero
);
    logic [BYTE_W-1:0] sum_nxt;

    assign sum_nxt = sum + byte_in;
    assign zero    = (sum_nxt == '0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum_nxt;
        end
    end
endmodule

// File: rtl/ins_loader.sv
// Packs a checksummed byte stream into 16-bit words written to instruction memory.
// Latency: word write 1 cycle after its high byte; done 1 cycle after checksum byte. Backpressure: in_ready low outside receive states; in_valid low stalls forever.
module ins_loader import ins_loader_pkg::*; (
    input  logic          clk,
    input  logic          rst,
    ins_loader_if.master  bus
);
    state_t            state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   idx_inc;
    logic [ADDR_W:0]   clamped;
    logic [BYTE_W-1:0] lo_byte;
    logic [BYTE_W-1:0] sum;
    logic              sum_zero;
    logic              accept;
    logic              csum_clr;
    logic              csum_add;

    assign accept   = bus.in_valid && bus.in_ready;
    assign idx_inc  = idx + (ADDR_W+1)'(1);
    assign clamped  = (bus.word_count > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.word_count;
    assign csum_clr = (state == ST_IDLE) && bus.start;
    assign csum_add = accept && ((state == ST_RECV_LO) || (state == ST_RECV_HI));

    ins_loader_csum u_csum (
        .clk     (clk),
        .rst     (rst),
        .clr     (csum_clr),
        .add_en  (csum_add),
        .byte_in (bus.in_data),
        .sum     (sum),
        .zero    (sum_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            idx          <= '0;
            lo_byte      <= '0;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.cpu_hold <= 1'b1;
        end else begin
            bus.wr_en <= 1'b0;
            bus.done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        count        <= clamped;
                        idx          <= '0;
                        bus.err      <= 1'b0;
                        bus.cpu_hold <= 1'b1;
                        bus.busy     <= 1'b1;
                        bus.in_ready <= 1'b1;
                        state        <= (clamped == '0) ? ST_CHECK : ST_RECV_LO;
                    end
                end
                ST_RECV_LO: begin
                    if (accept) begin
                        lo_byte <= bus.in_data;
                        state   <= ST_RECV_HI;
                    end
                end
                ST_RECV_HI: begin
                    if (accept) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= idx[ADDR_W-1:0];
                        bus.wr_data <= {bus.in_data, lo_byte};
                        idx         <= idx_inc;
                        state       <= (idx_inc == count) ? ST_CHECK : ST_RECV_LO;
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        bus.err      <= !sum_zero;
                        bus.done     <= 1'b1;
                        bus.in_ready <= 1'b0;
                        state        <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    // A bad image keeps the CPU parked in reset.
                    bus.cpu_hold <= bus.err;
                    bus.busy     <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
